// File: rtl/serial_out_ctrl.sv
// serial_out_ctrl: shares the single SERIAL_OUT pin between the CPU byte path
// (requester 0) and the debug/trace byte path (requester 1). A round-robin
// arbiter picks one byte per frame. A shift engine then sends it as an
// asynchronous frame: start bit, 8 data bits LSB first, optional parity, stop.
// Optional feature macro: SERIAL_PARITY_EN (inserts an even-parity bit).
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | line high, not busy; arbitrate registered requests
// S_START  | start bit, line low
// S_DATA   | data bits 0..7 from the shift register LSB
// S_PARITY | even parity over the captured byte (SERIAL_PARITY_EN only)
// S_STOP   | stop bit, line high
module serial_out_ctrl #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       REQ0,
  input  logic [7:0] DATA0,
  output logic       ACK0,
  input  logic       REQ1,
  input  logic [7:0] DATA1,
  output logic       ACK1,
  output logic       SERIAL_OUT,
  output logic       BUSY,
  output logic       GRANT_ID
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             req0_q, req1_q;
  logic             prio_q;
  logic             grant_id_q;
  logic             ack0_q, ack1_q;
  logic             bit_end;
  logic             grant;
  logic             win;
  logic             line;
  logic [7:0]       data_sel;
`ifdef SERIAL_PARITY_EN
  logic             par_q;
`endif

  assign bit_end = (baud_q == '0);

  // State register.
  always_ff @(posedge CLK) begin
    if (CLR) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state, arbitration decision and serial line level.
  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    win      = 1'b0;
    line     = 1'b1;
    data_sel = DATA0;
    case (state_q)
      S_IDLE: begin
        if (req0_q || req1_q) begin
          grant   = 1'b1;
          // Requester 1 wins when alone, or when both pend and it holds priority.
          win     = req1_q && (!req0_q || prio_q);
          state_d = S_START;
        end
        data_sel = win ? DATA1 : DATA0;
      end
      S_START: begin
        line = 1'b0;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        line = shift_q[0];
        if (bit_end && (bit_q == 3'd0)) begin
`ifdef SERIAL_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef SERIAL_PARITY_EN
      S_PARITY: begin
        line = par_q;
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request sampling, grant bookkeeping, baud/bit counters and shift register.
  // Requests pass through one register stage, so a grant lands one edge after
  // the request is sampled; the registered copy also lets a requester still
  // high during STOP be granted right after a single IDLE cycle.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      req0_q     <= 1'b0;
      req1_q     <= 1'b0;
      prio_q     <= 1'b0;
      grant_id_q <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      shift_q    <= 8'd0;
`ifdef SERIAL_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      req0_q <= REQ0;
      req1_q <= REQ1;
      ack0_q <= grant && !win;
      ack1_q <= grant && win;
      if (grant) begin
        shift_q    <= data_sel;
        grant_id_q <= win;
        prio_q     <= !win;
        baud_q     <= CNT_MAX;
        bit_q      <= 3'd7;
`ifdef SERIAL_PARITY_EN
        par_q      <= ^data_sel;
`endif
      end else if (state_q != S_IDLE) begin
        if (bit_end) begin
          baud_q <= CNT_MAX;
          if (state_q == S_DATA) begin
            shift_q <= {1'b0, shift_q[7:1]};
            bit_q   <= bit_q - 3'd1;
          end
        end else begin
          baud_q <= baud_q - CNT_W'(1);
        end
      end
    end
  end

  assign SERIAL_OUT = line;
  assign BUSY       = (state_q != S_IDLE);
  assign ACK0       = ack0_q;
  assign ACK1       = ack1_q;
  assign GRANT_ID   = grant_id_q;

endmodule
